// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB4 memory slave.
// FSM states, wait-counter width and response codes.
package apb_slv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int   CNT_W      = 4;
   localparam logic RESP_OKAY  = 1'b0;
   localparam logic RESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_slv_mem.sv
// Byte-enabled word storage for the APB4 memory slave.
// Synchronous write, combinational read, async clear.
module apb_slv_mem #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 64,
   localparam int NB     = DATA_W / 8,
   localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [IW-1:0]     idx_i,
   input  logic [NB-1:0]     strb_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Clear on reset; write enabled byte lanes on commit
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         for (int b = 0; b < NB; b++) begin
            if (strb_i[b]) begin
               mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 slave fronting a word memory with wait states.
// Bad index or misaligned address answers with pslverr.
module apb4_mem_slave
   import apb_slv_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 12,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_W-1:0]     paddr,
   input  logic [DATA_W-1:0]     pwdata,
   input  logic [DATA_W/8-1:0]   pstrb,
   output logic [DATA_W-1:0]     prdata,
   output logic                  pready,
   output logic                  pslverr
);

   localparam int NB  = DATA_W / 8;
   localparam int LSB = $clog2(NB);
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   apb_state_e        state_q, state_d, st_cur;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [NB-1:0]     strb_q, strb_d;

   logic              done;
   logic              err;
   logic              misal;
   logic [ADDR_W-1:0] idx_full;
   logic [DATA_W-1:0] mem_rdata;

   // Setup phase is recognised in the cycle it is on the bus
   always_comb begin
      st_cur = state_q;
      if (state_q == IDLE && psel && !penable) begin
         st_cur = SETUP;
      end
   end

   // Next-state, capture and wait-count logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      done    = 1'b0;
      unique case (st_cur)
         IDLE: begin
            state_d = IDLE;
         end
         SETUP: begin
            addr_d  = paddr;
            wr_d    = pwrite;
            wdata_d = pwdata;
            strb_d  = pstrb;
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = ACCESS;
         end
         ACCESS: begin
            if (!psel) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (penable) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and captured-request registers
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
      end
   end

   // Address decode of the captured request
   always_comb begin
      idx_full = addr_q >> LSB;
      misal    = (addr_q & ADDR_W'(NB - 1)) != '0;
      err      = misal || (idx_full >= ADDR_W'(DEPTH));
   end

   apb_slv_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk_i   (pclk),
      .rst_ni  (presetn),
      .we_i    (done && wr_q && !err),
      .idx_i   (idx_full[IW-1:0]),
      .strb_i  (strb_q),
      .wdata_i (wdata_q),
      .rdata_o (mem_rdata)
   );

   // Response only in the completion cycle
   always_comb begin
      pready  = done;
      pslverr = done ? (err ? RESP_ERROR : RESP_OKAY) : 1'b0;
      prdata  = '0;
      if (done && !wr_q && !err) begin
         prdata = mem_rdata;
      end
   end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Bench for apb4_mem_slave: three DUTs with 0, 3, 2 waits.
// Directed cases then random traffic against a word model.
module tb_apb4_mem_slave;

   logic        pclk = 1'b0;
   logic        presetn;
   logic [2:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata [3];
   logic        pready [3];
   logic        pslverr [3];

   int checks = 0;
   int errors = 0;
   logic [31:0] mdl [3][64];
   int wts [3] = '{0, 3, 2};
   logic [31:0] rd;

   always #5 pclk = ~pclk;

   apb4_mem_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
      .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

   apb4_mem_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(64), .WAIT_CYCLES(3)) u_w3 (
      .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

   apb4_mem_slave #(.DATA_W(32), .ADDR_W(12), .DEPTH(64), .WAIT_CYCLES(2)) u_w2 (
      .pclk(pclk), .presetn(presetn), .psel(psel[2]), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 64; i++)
            mdl[d][i] = '0;
   endtask

   task automatic outs_zero(input string tag);
      for (int d = 0; d < 3; d++) begin
         chk(tag, {30'b0, pready[d], pslverr[d]}, 32'h0);
         chk(tag, prdata[d], 32'h0);
      end
   endtask

   // Called just after a rising edge; returns just after the completion edge
   task automatic do_xfer(input int d, input logic wr, input logic [11:0] a,
                          input logic [31:0] wd, input logic [3:0] st,
                          output logic [31:0] r);
      bit          err;
      int          idx;
      logic [31:0] exp_rd;
      r      = '0;
      idx    = int'(a) / 4;
      err    = (idx >= 64) || (a % 4 != 0);
      exp_rd = '0;
      if (!wr && !err) exp_rd = mdl[d][idx];
      psel    = '0;
      psel[d] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = wd;
      pstrb   = st;
      @(negedge pclk);
      chk("setup_rdy", {31'b0, pready[d]}, 32'h0);
      @(posedge pclk);
      #1;
      penable = 1'b1;
      pwrite  = ~wr;
      paddr   = ~a;
      pwdata  = ~wd;
      pstrb   = ~st;
      for (int k = 0; k <= wts[d]; k++) begin
         @(negedge pclk);
         chk("pready", {31'b0, pready[d]}, {31'b0, k == wts[d]});
         if (k == wts[d]) begin
            chk("pslverr", {31'b0, pslverr[d]}, {31'b0, err});
            chk("prdata", prdata[d], exp_rd);
            r = prdata[d];
         end else begin
            chk("wait_err", {31'b0, pslverr[d]}, 32'h0);
            chk("wait_rdata", prdata[d], 32'h0);
         end
         @(posedge pclk);
         #1;
      end
      penable = 1'b0;
      if (wr && !err)
         for (int b = 0; b < 4; b++)
            if (st[b]) mdl[d][idx][b*8 +: 8] = wd[b*8 +: 8];
   endtask

   task automatic idle(input int d);
      psel    = '0;
      penable = 1'b0;
      @(negedge pclk);
      chk("idle_rdy", {31'b0, pready[d]}, 32'h0);
      chk("idle_rdata", prdata[d], 32'h0);
      @(posedge pclk);
      #1;
   endtask

   initial begin
      presetn = 1'b0;
      psel    = '0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
      model_reset();
      #12;
      outs_zero("reset_outs");
      @(posedge pclk);
      #1;
      presetn = 1'b1;

      // penable without a setup phase is ignored
      psel    = 3'b001;
      penable = 1'b1;
      repeat (2) begin
         @(negedge pclk);
         chk("no_setup_rdy", {31'b0, pready[0]}, 32'h0);
         @(posedge pclk);
         #1;
      end
      idle(0);

      // zero-wait write then read
      do_xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, rd);
      idle(0);
      do_xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, rd);
      chk("rd_deadbeef", rd, 32'hDEADBEEF);
      idle(0);

      // three waits, partial strobes
      do_xfer(1, 1'b1, 12'h000, 32'hFFFFFFFF, 4'hF, rd);
      idle(1);
      do_xfer(1, 1'b1, 12'h000, 32'h11223344, 4'h5, rd);
      idle(1);
      do_xfer(1, 1'b0, 12'h000, 32'h0, 4'hF, rd);
      chk("rd_strb", rd, 32'hFF22FF44);
      idle(1);

      // out-of-range and misaligned errors
      do_xfer(0, 1'b0, 12'h100, 32'h0, 4'hF, rd);
      idle(0);
      do_xfer(0, 1'b1, 12'h002, 32'h12345678, 4'hF, rd);
      idle(0);
      do_xfer(0, 1'b0, 12'h000, 32'h0, 4'hF, rd);
      chk("rd_after_err", rd, 32'h0);
      idle(0);

      // abort after one access cycle
      psel    = 3'b100;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 12'h020;
      pwdata  = 32'hA5A5A5A5;
      pstrb   = 4'hF;
      @(posedge pclk);
      #1;
      penable = 1'b1;
      @(negedge pclk);
      chk("abort_wait", {31'b0, pready[2]}, 32'h0);
      @(posedge pclk);
      #1;
      psel    = '0;
      penable = 1'b0;
      @(negedge pclk);
      chk("abort_rdy", {30'b0, pready[2], pslverr[2]}, 32'h0);
      @(posedge pclk);
      #1;
      do_xfer(2, 1'b0, 12'h020, 32'h0, 4'hF, rd);
      chk("rd_abort", rd, 32'h0);
      idle(2);

      // reset during the wait of a write
      psel    = 3'b010;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 12'h030;
      pwdata  = 32'hCAFEF00D;
      pstrb   = 4'hF;
      @(posedge pclk);
      #1;
      penable = 1'b1;
      @(negedge pclk);
      chk("rst_wait", {31'b0, pready[1]}, 32'h0);
      @(posedge pclk);
      #2;
      presetn = 1'b0;
      #1;
      outs_zero("mid_reset");
      model_reset();
      @(posedge pclk);
      #1;
      presetn = 1'b1;
      do_xfer(1, 1'b0, 12'h030, 32'h0, 4'hF, rd);
      chk("rd_rst_30", rd, 32'h0);
      do_xfer(1, 1'b0, 12'h000, 32'h0, 4'hF, rd);
      chk("rd_rst_00", rd, 32'h0);
      idle(1);

      // back-to-back write then read
      do_xfer(0, 1'b1, 12'h004, 32'h1, 4'hF, rd);
      do_xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, rd);
      chk("rd_b2b", rd, 32'h1);
      idle(0);

      // random traffic
      for (int n = 0; n < 60; n++) begin
         int          d;
         int          pick;
         logic [11:0] a;
         d    = int'($urandom_range(0, 2));
         pick = int'($urandom_range(0, 9));
         if (pick == 0)
            a = 12'(12'h100 + 4 * $urandom_range(0, 100));
         else if (pick == 1)
            a = 12'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
         else
            a = 12'(4 * $urandom_range(0, 15));
         do_xfer(d, 1'($urandom_range(0, 1)), a, $urandom,
                 4'($urandom_range(0, 15)), rd);
         if ($urandom_range(0, 2) == 0) idle(d);
      end
      idle(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
